// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package tinker_mem_pkg;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_IF,
    TAG_LS_RD,
    TAG_LS_WR,
    TAG_LS_ERR
  } tag_e;

  localparam int MEM_BYTES_DFLT = 524288;
  localparam int ACCESS_BYTES   = 8;

  // An 8-byte access fits only if its last byte is still inside the array.
  function automatic logic in_range(input logic [63:0] addr, input int mem_bytes);
    return addr <= 64'(mem_bytes - ACCESS_BYTES);
  endfunction

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Fetch, load/store and memory-array signals of the arbiter, grouped as one bus.
interface tinker_mem_arbiter_if;

  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_flush;
  logic        if_rvalid;
  logic [63:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        ls_err;

  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic        busy;

  // Requester/memory-array side.
  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/tinker_resp_tracker.sv
// RD_LAT-deep tag shift register that routes each memory response back to its
// requester; flush turns every in-flight fetch tag into an empty slot.
module tinker_resp_tracker
  import tinker_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_e tag_in,
  input  logic flush,
  output tag_e tag_out,
  output logic busy
);

  tag_e tag_pipe [RD_LAT];

  function automatic tag_e squash(input tag_e t, input logic f);
    return (f && (t == TAG_IF)) ? TAG_NONE : t;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= squash(tag_in, flush);
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= squash(tag_pipe[i-1], flush);
    end
  end

  assign tag_out = tag_pipe[RD_LAT-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (tag_pipe[i] != TAG_NONE) busy = 1'b1;
    end
  end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares the single unified memory port between fetch and load/store, with a
// starvation limit on consecutive LSU wins and tag-based response routing.
module tinker_mem_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int MEM_BYTES  = MEM_BYTES_DFLT,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  tinker_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_ok;
  logic             ls_win;
  logic             if_win;
  logic             ls_in_rng;
  logic             if_in_rng;
  tag_e             tag_in;
  tag_e             tag_out;
  logic             trk_busy;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v < STARVE_LIM) ? v + 1'b1 : v;
  endfunction

  // Grant stage: combinational winner selection and memory strobe.
  always_comb begin
    if_ok     = bus.if_req && (bus.if_addr[2:0] == 3'b000);
    ls_win    = !reset && bus.ls_req && ((starve_cnt < STARVE_LIM) || !if_ok);
    if_win    = !reset && !ls_win && if_ok;
    ls_in_rng = in_range(bus.ls_addr, MEM_BYTES);
    if_in_rng = in_range(bus.if_addr, MEM_BYTES);

    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    tag_in        = TAG_NONE;

    if (ls_win) begin
      bus.mem_en    = ls_in_rng;
      bus.mem_we    = ls_in_rng && bus.ls_we;
      bus.mem_addr  = bus.ls_addr;
      bus.mem_wdata = bus.ls_wdata;
      if (!ls_in_rng)     tag_in = TAG_LS_ERR;
      else if (bus.ls_we) tag_in = TAG_LS_WR;
      else                tag_in = TAG_LS_RD;
    end else if (if_win) begin
      bus.mem_en   = if_in_rng;
      bus.mem_addr = bus.if_addr;
      tag_in       = TAG_IF;
    end
  end

  assign bus.if_gnt = if_win;
  assign bus.ls_gnt = ls_win;

  // The count only matters while a fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || if_win) begin
      starve_cnt <= '0;
    end else if (ls_win) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  tinker_resp_tracker #(
    .RD_LAT (RD_LAT)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .flush   (bus.if_flush),
    .tag_out (tag_out),
    .busy    (trk_busy)
  );

  // Response stage: tail tag steers mem_rdata; a tail fetch is dropped on flush.
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = '0;
    bus.ls_err    = 1'b0;
    if (!reset) begin
      unique case (tag_out)
        TAG_IF: begin
          if (!bus.if_flush) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
          end
        end
        TAG_LS_RD: begin
          bus.ls_rvalid = 1'b1;
          bus.ls_rdata  = bus.mem_rdata;
        end
        TAG_LS_WR:  bus.ls_rvalid = 1'b1;
        TAG_LS_ERR: begin
          bus.ls_rvalid = 1'b1;
          bus.ls_err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = trk_busy;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Drives three arbiters (RD_LAT = 1, 2, 3) with identical stimulus; a byte-level
// memory model predicts grants and responses, a negedge monitor checks them.
module tb_tinker_mem_arbiter;
  import tinker_mem_pkg::*;

  localparam int MEMB  = 524288;
  localparam int WORDS = MEMB / 8;
  localparam int NI    = 3;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [63:0] ls_addr = '0;
  logic [63:0] ls_wdata = '0;

  logic [NI-1:0] if_gnt_a, ls_gnt_a, if_rvalid_a, ls_rvalid_a, ls_err_a;
  logic [NI-1:0] mem_en_a, mem_we_a, busy_a;
  logic [63:0]   if_rdata_a [NI];
  logic [63:0]   ls_rdata_a [NI];
  logic [63:0]   mem_addr_a [NI];
  logic [63:0]   mem_wdata_a [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int starve   = 0;
  logic m_if, m_ls, dut_if, dut_ls;

  typedef struct {
    int            gcyc;
    logic [63:0]   data;
    logic          err;
    logic [NI-1:0] dead;
  } exp_t;

  exp_t ifq[$];
  exp_t lsq[$];

  logic [7:0] ref_mem [MEMB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int k);
    return 8'((k * 37) ^ (k >> 7) ^ 32'h5A);
  endfunction

  function automatic logic [63:0] init_word(input int w);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = init_byte(8 * w + j);
    return r;
  endfunction

  function automatic logic [63:0] rd_ref(input logic [63:0] a);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = ref_mem[int'(a[18:0]) + j];
    return r;
  endfunction

  task automatic wr_ref(input logic [63:0] a, input logic [63:0] d);
    for (int j = 0; j < 8; j++) ref_mem[int'(a[18:0]) + j] = d[8*j +: 8];
  endtask

  initial for (int k = 0; k < MEMB; k++) ref_mem[k] = init_byte(k);

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = g + 1;
    tinker_mem_arbiter_if bus();
    logic [63:0] emem [WORDS];
    logic [63:0] rd_pipe [L];

    assign bus.if_req    = if_req;
    assign bus.if_addr   = if_addr;
    assign bus.if_flush  = if_flush;
    assign bus.ls_req    = ls_req;
    assign bus.ls_we     = ls_we;
    assign bus.ls_addr   = ls_addr;
    assign bus.ls_wdata  = ls_wdata;
    assign bus.mem_rdata = rd_pipe[L-1];

    tinker_mem_arbiter #(
      .MEM_BYTES  (MEMB),
      .RD_LAT     (L),
      .STARVE_MAX (SMAX)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    initial for (int i = 0; i < WORDS; i++) emem[i] = init_word(i);

    // Memory array with fixed read latency; idle slots carry a poison pattern.
    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) emem[bus.mem_addr[18:3]] <= bus.mem_wdata;
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? emem[bus.mem_addr[18:3]]
                                                 : 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign if_gnt_a[g]    = bus.if_gnt;
    assign ls_gnt_a[g]    = bus.ls_gnt;
    assign if_rvalid_a[g] = bus.if_rvalid;
    assign ls_rvalid_a[g] = bus.ls_rvalid;
    assign ls_err_a[g]    = bus.ls_err;
    assign mem_en_a[g]    = bus.mem_en;
    assign mem_we_a[g]    = bus.mem_we;
    assign busy_a[g]      = bus.busy;
    assign if_rdata_a[g]  = bus.if_rdata;
    assign ls_rdata_a[g]  = bus.ls_rdata;
    assign mem_addr_a[g]  = bus.mem_addr;
    assign mem_wdata_a[g] = bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One cycle: predict grants from the rules, compare, queue expected responses.
  task automatic step();
    logic        if_ok, oor, e_en, e_we;
    logic [63:0] e_addr, e_wd;
    @(negedge clk);
    if_ok = if_req && (if_addr[2:0] == 3'b000);
    m_ls  = !reset && ls_req && ((starve < SMAX) || !if_ok);
    m_if  = !reset && !m_ls && if_ok;
    oor   = ls_addr > 64'(MEMB - 8);
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (m_ls) begin
      e_en = !oor; e_we = !oor && ls_we; e_addr = ls_addr; e_wd = ls_wdata;
    end else if (m_if) begin
      e_en = if_addr <= 64'(MEMB - 8); e_addr = if_addr;
    end
    dut_if = if_gnt_a[0];
    dut_ls = ls_gnt_a[0];
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("if_gnt[%0d]", g), 64'(if_gnt_a[g]), 64'(m_if));
      chk($sformatf("ls_gnt[%0d]", g), 64'(ls_gnt_a[g]), 64'(m_ls));
      chk($sformatf("mem_en[%0d]", g), 64'(mem_en_a[g]), 64'(e_en));
      if (e_en) begin
        chk($sformatf("mem_we[%0d]", g), 64'(mem_we_a[g]), 64'(e_we));
        chk($sformatf("mem_addr[%0d]", g), mem_addr_a[g], e_addr);
        if (e_we) chk($sformatf("mem_wdata[%0d]", g), mem_wdata_a[g], e_wd);
      end
    end
    if (m_if && !if_flush) ifq.push_back('{cyc, rd_ref(if_addr), 1'b0, '0});
    if (m_ls) begin
      if (oor) lsq.push_back('{cyc, 64'd0, 1'b1, '0});
      else if (ls_we) begin
        wr_ref(ls_addr, ls_wdata);
        lsq.push_back('{cyc, 64'd0, 1'b0, '0});
      end else lsq.push_back('{cyc, rd_ref(ls_addr), 1'b0, '0});
    end
    if (reset || !if_req || m_if) starve = 0;
    else if (m_ls && starve < SMAX) starve++;
    @(posedge clk);
    #1;
  endtask

  task automatic mon_inst(input int g);
    int          l;
    logic        be, ev, ee;
    logic [63:0] ed;
    exp_t        e;
    l = g + 1;
    if (!reset) begin
      be = 1'b0;
      foreach (ifq[i]) if (ifq[i].gcyc < cyc && ifq[i].gcyc + l >= cyc && !ifq[i].dead[g]) be = 1'b1;
      foreach (lsq[i]) if (lsq[i].gcyc < cyc && lsq[i].gcyc + l >= cyc && !lsq[i].dead[g]) be = 1'b1;
      chk($sformatf("busy[%0d]", g), 64'(busy_a[g]), 64'(be));
    end
    foreach (ifq[i]) if ((reset || if_flush) && ifq[i].gcyc + l >= cyc) begin
      e = ifq[i]; e.dead[g] = 1'b1; ifq[i] = e;
    end
    foreach (lsq[i]) if (reset && lsq[i].gcyc + l >= cyc) begin
      e = lsq[i]; e.dead[g] = 1'b1; lsq[i] = e;
    end
    ev = 1'b0; ed = '0;
    foreach (ifq[i]) if (ifq[i].gcyc + l == cyc && !ifq[i].dead[g]) begin ev = 1'b1; ed = ifq[i].data; end
    chk($sformatf("if_rvalid[%0d]", g), 64'(if_rvalid_a[g]), 64'(ev));
    if (ev) chk($sformatf("if_rdata[%0d]", g), if_rdata_a[g], ed);
    ev = 1'b0; ed = '0; ee = 1'b0;
    foreach (lsq[i]) if (lsq[i].gcyc + l == cyc && !lsq[i].dead[g]) begin
      ev = 1'b1; ed = lsq[i].data; ee = lsq[i].err;
    end
    chk($sformatf("ls_rvalid[%0d]", g), 64'(ls_rvalid_a[g]), 64'(ev));
    if (ev) begin
      chk($sformatf("ls_rdata[%0d]", g), ls_rdata_a[g], ed);
      chk($sformatf("ls_err[%0d]", g), 64'(ls_err_a[g]), 64'(ee));
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) mon_inst(g);
    while (ifq.size() > 0 && ifq[0].gcyc + NI < cyc) void'(ifq.pop_front());
    while (lsq.size() > 0 && lsq[0].gcyc + NI < cyc) void'(lsq.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int if_age;
    @(posedge clk);
    #1;
    // Requests under reset must not be granted.
    reset = 1'b1; if_req = 1'b1; if_addr = 64'h2000; ls_req = 1'b1; ls_addr = 64'h40;
    step(); step();
    reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    step();

    // Lone fetch.
    if_req = 1'b1; if_addr = 64'h2000;
    step();
    chk("fetch_alone_gnt", 64'(dut_if), 64'd1);
    if_req = 1'b0;
    repeat (3) step();

    // Store, load back, then fetches right after stores.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h1000; ls_wdata = 64'hDEADBEEF_CAFEF00D;
    step();
    chk("store_gnt", 64'(dut_ls), 64'd1);
    ls_we = 1'b0;
    step();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 64'h1000;
    step();
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h1008; ls_wdata = 64'h0123_4567_89AB_CDEF;
    step();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 64'h1008;
    step();
    if_req = 1'b0;
    repeat (4) step();

    // Both requesters held: four LSU wins, then one fetch.
    if_req = 1'b1; if_addr = 64'h3000; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h3008;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("starve_pattern", 64'({dut_if, dut_ls}), (k % 5 == 4) ? 64'd2 : 64'd1);
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) step();

    // Three back-to-back fetches, flush on the third, then a load.
    if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_addr = 64'h4000 + 64'(8 * k);
      if_flush = (k == 2);
      step();
    end
    if_flush = 1'b0; if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h4100;
    step();
    ls_req = 1'b0;
    repeat (4) step();

    // Range boundary and misaligned fetch.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h7FFF9; if_req = 1'b1; if_addr = 64'h2004;
    step();
    chk("oor_ls_gnt", 64'(dut_ls), 64'd1);
    chk("misaligned_if_gnt", 64'(dut_if), 64'd0);
    ls_we = 1'b1; ls_wdata = 64'h1111_2222_3333_4444;
    step();
    ls_we = 1'b0; ls_addr = 64'h7FFF8;
    step();
    ls_addr = 64'h1_0000_0000;
    step();
    ls_we = 1'b1; ls_addr = 64'h7FFF8; ls_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
    step();
    ls_we = 1'b0;
    step();
    chk("misaligned_if_still_blocked", 64'(dut_if), 64'd0);
    ls_req = 1'b0; if_req = 1'b0;
    repeat (3) step();

    // Reset with reads in flight.
    if_req = 1'b1; if_addr = 64'h5000;
    step();
    if_addr = 64'h5008;
    step();
    if_req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();

    // Randomized traffic with random flushes.
    if_age = 0;
    for (int n = 0; n < 400; n++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_age = 0;
        if_addr = 64'h2000 + 64'(8 * $urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) if_addr[2:0] = 3'b100;
      end
      if (!ls_req && $urandom_range(0, 1) == 0) begin
        ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
        ls_addr = 64'h2000 + 64'(8 * $urandom_range(0, 31));
        ls_wdata = {$urandom, $urandom};
        if ($urandom_range(0, 9) == 0) ls_addr = 64'(MEMB - 8 + $urandom_range(1, 16));
      end
      if_flush = ($urandom_range(0, 9) == 0);
      step();
      if (m_if) if_req = 1'b0;
      else if (if_req) begin
        if_age++;
        if (if_addr[2:0] != 3'b000 && if_age > 3) if_req = 1'b0;
      end
      if (m_ls) ls_req = 1'b0;
    end
    if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
